// File: rtl/tl_ul_sram_slave.sv
// TileLink-UL slave backed by a byte-masked, synchronous-read SRAM of 64-bit words.
// Serves Get/PutFull/PutPartial bursts up to 2^MAX_LGSIZE bytes, one transaction at a time.
//
// state | meaning
// IDLE  | waiting for a new A request
// PUT   | collecting the remaining write beats of a burst
// GET   | issuing reads and streaming AccessAckData beats
// ACK   | holding the single AccessAck until consumed
module tl_ul_sram_slave #(
    parameter logic [30:0] ADDR_BASE   = 31'h1000_0000,
    parameter int          DEPTH_WORDS = 512,
    parameter int          MAX_LGSIZE  = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [2:0]  auto_in_a_bits_size,
    input  logic [7:0]  auto_in_a_bits_source,
    input  logic [30:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    output logic        auto_in_a_ready,
    output logic        auto_in_d_valid,
    input  logic        auto_in_d_ready,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [2:0]  auto_in_d_bits_size,
    output logic [7:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);

    localparam int          IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WIN_LO = {1'b0, ADDR_BASE};
    localparam logic [31:0] WIN_HI = WIN_LO + 32'(DEPTH_WORDS) * 32'd8;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PUT,
        ST_GET,
        ST_ACK
    } state_e;

    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [4:0]         last_q, last_d;
    logic [IDX_W-1:0]   base_q, base_d;
    logic               denied_q, denied_d;
    logic               a_ready_q, a_ready_d;
    logic               d_valid_q, d_valid_d;
    logic [2:0]         d_opcode_q, d_opcode_d;
    logic [2:0]         d_size_q, d_size_d;
    logic [7:0]         d_source_q, d_source_d;
    logic               d_denied_q, d_denied_d;
    logic               d_corrupt_q, d_corrupt_d;
    logic               d_zero_q, d_zero_d;

    logic [63:0]        mem [DEPTH_WORDS];
    logic [63:0]        rd_data_q;

    logic               a_fire;
    logic [31:0]        req_addr;
    logic [31:0]        req_offset;
    logic               req_in_win;
    logic               req_size_ok;
    logic               req_get;
    logic               req_put;
    logic               req_denied;
    logic [4:0]         req_last;
    logic [IDX_W-1:0]   req_word;
    logic [IDX_W-1:0]   req_base;

    logic               rd_en;
    logic               rd_denied;
    logic [IDX_W-1:0]   rd_idx;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [7:0]         wr_be;
    logic               ack_set;
    logic               ack_denied;
    logic               all_issued;

    // Request decode for the beat currently presented on A.
    assign a_fire      = auto_in_a_valid & a_ready_q;
    assign req_addr    = {1'b0, auto_in_a_bits_address};
    assign req_offset  = req_addr - WIN_LO;
    assign req_in_win  = (req_addr >= WIN_LO) && (req_addr < WIN_HI);
    assign req_size_ok = auto_in_a_bits_size <= 3'(MAX_LGSIZE);
    assign req_get     = auto_in_a_bits_opcode == OP_GET;
    assign req_put     = (auto_in_a_bits_opcode == OP_PUT_FULL) ||
                         (auto_in_a_bits_opcode == OP_PUT_PARTIAL);
    assign req_denied  = !req_in_win || !req_size_ok || !(req_get || req_put);
    assign req_word    = req_offset[IDX_W+2:3];
    assign req_base    = req_word & ~IDX_W'(req_last);

    always_comb begin
        req_last = '0;
        if (auto_in_a_bits_size > 3'd3) begin
            req_last = (5'd1 << (auto_in_a_bits_size - 3'd3)) - 5'd1;
        end
    end

    assign all_issued = cnt_q > last_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        base_d      = base_q;
        denied_d    = denied_q;
        d_valid_d   = d_valid_q;
        d_opcode_d  = d_opcode_q;
        d_size_d    = d_size_q;
        d_source_d  = d_source_q;
        d_denied_d  = d_denied_q;
        d_corrupt_d = d_corrupt_q;
        d_zero_d    = d_zero_q;
        rd_en       = 1'b0;
        rd_denied   = denied_q;
        rd_idx      = base_q + IDX_W'(cnt_q);
        wr_en       = 1'b0;
        wr_idx      = base_q + IDX_W'(cnt_q);
        wr_be       = auto_in_a_bits_mask & {8{~auto_in_a_bits_corrupt}};
        ack_set     = 1'b0;
        ack_denied  = denied_q;

        unique case (state_q)
            ST_IDLE: begin
                if (a_fire) begin
                    base_d     = req_base;
                    last_d     = req_last;
                    denied_d   = req_denied;
                    cnt_d      = 5'd1;
                    d_size_d   = auto_in_a_bits_size;
                    d_source_d = auto_in_a_bits_source;
                    if (req_get) begin
                        rd_en     = 1'b1;
                        rd_idx    = req_base;
                        rd_denied = req_denied;
                        state_d   = ST_GET;
                    end else if (req_put) begin
                        wr_en  = !req_denied;
                        wr_idx = req_base;
                        if (req_last == 5'd0) begin
                            ack_set    = 1'b1;
                            ack_denied = req_denied;
                            state_d    = ST_ACK;
                        end else begin
                            state_d = ST_PUT;
                        end
                    end else begin
                        ack_set    = 1'b1;
                        ack_denied = 1'b1;
                        state_d    = ST_ACK;
                    end
                end
            end
            ST_PUT: begin
                if (a_fire) begin
                    wr_en = !denied_q;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == last_q) begin
                        ack_set = 1'b1;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_GET: begin
                // A read may only replace the D register once its beat is gone.
                if (!d_valid_q || auto_in_d_ready) begin
                    if (!all_issued) begin
                        rd_en = 1'b1;
                        cnt_d = cnt_q + 5'd1;
                    end else begin
                        d_valid_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_ACK: begin
                if (auto_in_d_ready) begin
                    d_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ack_set) begin
            d_valid_d   = 1'b1;
            d_opcode_d  = OP_ACK;
            d_denied_d  = ack_denied;
            d_corrupt_d = 1'b0;
            d_zero_d    = 1'b1;
        end
        if (rd_en) begin
            d_valid_d   = 1'b1;
            d_opcode_d  = OP_ACK_DATA;
            d_denied_d  = rd_denied;
            d_corrupt_d = rd_denied;
            d_zero_d    = rd_denied;
        end

        a_ready_d = (state_d == ST_IDLE) || (state_d == ST_PUT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= '0;
            base_q      <= '0;
            denied_q    <= 1'b0;
            a_ready_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            d_opcode_q  <= '0;
            d_size_q    <= '0;
            d_source_q  <= '0;
            d_denied_q  <= 1'b0;
            d_corrupt_q <= 1'b0;
            d_zero_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            base_q      <= base_d;
            denied_q    <= denied_d;
            a_ready_q   <= a_ready_d;
            d_valid_q   <= d_valid_d;
            d_opcode_q  <= d_opcode_d;
            d_size_q    <= d_size_d;
            d_source_q  <= d_source_d;
            d_denied_q  <= d_denied_d;
            d_corrupt_q <= d_corrupt_d;
            d_zero_q    <= d_zero_d;
        end
    end

    // SRAM array and its read register carry no reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
                end
            end
        end
        if (rd_en && !rd_denied) begin
            rd_data_q <= mem[rd_idx];
        end
    end

    assign auto_in_a_ready        = a_ready_q;
    assign auto_in_d_valid        = d_valid_q;
    assign auto_in_d_bits_opcode  = d_opcode_q;
    assign auto_in_d_bits_param   = 2'd0;
    assign auto_in_d_bits_size    = d_size_q;
    assign auto_in_d_bits_source  = d_source_q;
    assign auto_in_d_bits_sink    = 1'b0;
    assign auto_in_d_bits_denied  = d_denied_q;
    assign auto_in_d_bits_corrupt = d_corrupt_q;
    assign auto_in_d_bits_data    = d_zero_q ? 64'd0 : rd_data_q;

    logic unused_bits;
    assign unused_bits = ^{auto_in_a_bits_param, req_offset[31:IDX_W+3], req_offset[2:0]};

endmodule

// File: tb/tb_tl_ul_sram_slave.sv
// Self-checking bench for tl_ul_sram_slave: directed scenarios plus random traffic
// compared against a transaction-level memory model.
module tb_tl_ul_sram_slave;

    localparam logic [30:0] BASE  = 31'h1000_0000;
    localparam int          DEPTH = 512;
    localparam int          WIN   = DEPTH * 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid;
    logic [2:0]  a_opcode, a_param, a_size;
    logic [7:0]  a_source;
    logic [30:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        a_corrupt;
    logic        a_ready;
    logic        d_valid, d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink, d_denied, d_corrupt;
    logic [63:0] d_data;

    always #5 clock = ~clock;

    tl_ul_sram_slave dut (
        .clock                  (clock),
        .reset                  (reset),
        .auto_in_a_valid        (a_valid),
        .auto_in_a_bits_opcode  (a_opcode),
        .auto_in_a_bits_param   (a_param),
        .auto_in_a_bits_size    (a_size),
        .auto_in_a_bits_source  (a_source),
        .auto_in_a_bits_address (a_address),
        .auto_in_a_bits_mask    (a_mask),
        .auto_in_a_bits_data    (a_data),
        .auto_in_a_bits_corrupt (a_corrupt),
        .auto_in_a_ready        (a_ready),
        .auto_in_d_valid        (d_valid),
        .auto_in_d_ready        (d_ready),
        .auto_in_d_bits_opcode  (d_opcode),
        .auto_in_d_bits_param   (d_param),
        .auto_in_d_bits_size    (d_size),
        .auto_in_d_bits_source  (d_source),
        .auto_in_d_bits_sink    (d_sink),
        .auto_in_d_bits_denied  (d_denied),
        .auto_in_d_bits_data    (d_data),
        .auto_in_d_bits_corrupt (d_corrupt)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] ref_mem [DEPTH];
    logic [63:0] bd [16];
    logic [7:0]  bm [16];
    logic        bc [16];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int beats_of(input logic [2:0] size);
        return (size > 3'd3) ? (1 << (int'(size) - 3)) : 1;
    endfunction

    function automatic bit is_denied(input logic [30:0] addr, input logic [2:0] size);
        longint a;
        a = longint'(addr);
        return (a < longint'(BASE)) || (a >= longint'(BASE) + WIN) || (size > 3'd6);
    endfunction

    function automatic int base_of(input logic [30:0] addr, input logic [2:0] size);
        longint w;
        int     nb;
        nb = beats_of(size);
        w  = ((longint'(addr) - longint'(BASE)) / 8) % DEPTH;
        return int'(w - (w % nb));
    endfunction

    function automatic logic ready_for(input int mode, input int p);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((p % 4) == 0) || ((p % 4) == 3);
        return $urandom_range(0, 2) != 0;
    endfunction

    task automatic drive_beat(input logic [2:0] op, input logic [2:0] size, input logic [7:0] src,
                              input logic [30:0] addr, input logic [7:0] mask, input logic [63:0] data,
                              input logic corr, output bit ok);
        int guard;
        a_opcode  = op;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_corrupt = corr;
        a_param   = 3'($urandom_range(0, 7));
        a_valid   = 1'b1;
        guard     = 0;
        while (!a_ready && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        if (!a_ready) begin
            check_eq("a_ready_wait", a_ready, 1);
            a_valid = 1'b0;
            ok = 1'b0;
        end else begin
            @(posedge clock); #1;
            a_valid = 1'b0;
            ok = 1'b1;
        end
    endtask

    task automatic wait_ack(input logic [7:0] src, input logic [2:0] size, input bit den, input int stall);
        int          g;
        logic [7:0]  snap_src;
        logic        snap_den;
        check_eq("ack_latency", d_valid, 1);
        g = 0;
        while (!d_valid && g < 50) begin
            @(posedge clock); #1;
            g++;
        end
        for (int s = 0; s < stall; s++) begin
            snap_src = d_source;
            snap_den = d_denied;
            @(posedge clock); #1;
            check_eq("ack_hold_valid", d_valid, 1);
            check_eq("ack_hold_src", d_source, snap_src);
            check_eq("ack_hold_denied", d_denied, snap_den);
            check_eq("ack_a_ready", a_ready, 0);
        end
        d_ready = 1'b1;
        check_eq("ack_opcode", d_opcode, 0);
        check_eq("ack_param", d_param, 0);
        check_eq("ack_sink", d_sink, 0);
        check_eq("ack_size", d_size, size);
        check_eq("ack_source", d_source, src);
        check_eq("ack_denied", d_denied, den);
        check_eq("ack_corrupt", d_corrupt, 0);
        @(posedge clock); #1;
        check_eq("ack_drop", d_valid, 0);
        check_eq("ack_a_ready_after", a_ready, 1);
        d_ready = 1'b0;
    endtask

    task automatic do_put(input logic [2:0] op, input logic [2:0] size, input logic [7:0] src,
                          input logic [30:0] addr, input int stall);
        int nb, bi, idx;
        bit den, ok;
        nb  = beats_of(size);
        den = is_denied(addr, size);
        bi  = den ? 0 : base_of(addr, size);
        d_ready = (stall == 0);
        for (int b = 0; b < nb; b++) begin
            drive_beat(op, size, src, addr, bm[b], bd[b], bc[b], ok);
            if (!ok) return;
        end
        if (!den) begin
            for (int b = 0; b < nb; b++) begin
                idx = (bi + b) % DEPTH;
                if (!bc[b]) begin
                    for (int i = 0; i < 8; i++) begin
                        if (bm[b][i]) ref_mem[idx][8*i +: 8] = bd[b][8*i +: 8];
                    end
                end
            end
        end
        wait_ack(src, size, den, stall);
    endtask

    task automatic do_bad(input logic [2:0] op, input logic [2:0] size, input logic [7:0] src,
                          input logic [30:0] addr, input int stall);
        bit ok;
        d_ready = (stall == 0);
        drive_beat(op, size, src, addr, 8'hFF, 64'd0, 1'b0, ok);
        if (ok) wait_ack(src, size, 1'b1, stall);
    endtask

    task automatic do_get(input logic [2:0] size, input logic [7:0] src, input logic [30:0] addr,
                          input int mode, output int cyc);
        int          nb, bi, got, p;
        bit          den, ok, pv, pr;
        logic [63:0] pdata, exp;
        logic        pden;
        nb  = beats_of(size);
        den = is_denied(addr, size);
        bi  = den ? 0 : base_of(addr, size);
        cyc = 0;
        d_ready = ready_for(mode, 0);
        drive_beat(3'd4, size, src, addr, 8'h00, 64'd0, 1'b0, ok);
        if (!ok) return;
        check_eq("get_latency", d_valid, 1);
        got = 0; p = 0; pv = 0; pr = 0; pdata = '0; pden = 0;
        while (got < nb && cyc < 400) begin
            check_eq("get_a_ready", a_ready, 0);
            if (pv && !pr) begin
                check_eq("hold_valid", d_valid, 1);
                check_eq("hold_data", d_data, pdata);
                check_eq("hold_denied", d_denied, pden);
            end
            if (d_valid && d_ready) begin
                exp = den ? 64'd0 : ref_mem[(bi + got) % DEPTH];
                check_eq("get_data", d_data, exp);
                check_eq("get_opcode", d_opcode, 1);
                check_eq("get_denied", d_denied, den);
                check_eq("get_corrupt", d_corrupt, den);
                check_eq("get_size", d_size, size);
                check_eq("get_source", d_source, src);
                got++;
            end
            pv = d_valid; pr = d_ready; pdata = d_data; pden = d_denied;
            @(posedge clock); #1;
            cyc++; p++;
            d_ready = ready_for(mode, p);
        end
        check_eq("get_beats", got, nb);
        check_eq("get_end_valid", d_valid, 0);
        check_eq("get_end_a_ready", a_ready, 1);
        d_ready = 1'b0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cyc, size, off, r, st;
        logic [2:0]  op, sz;
        logic [30:0] addr;
        bit          ok;

        reset = 1'b0; a_valid = 1'b0; d_ready = 1'b0;
        a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
        a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_d_valid", d_valid, 0);
        check_eq("rst_a_ready", a_ready, 0);
        check_eq("rst_d_opcode", d_opcode, 0);
        check_eq("rst_d_size", d_size, 0);
        check_eq("rst_d_source", d_source, 0);
        check_eq("rst_d_denied", d_denied, 0);
        check_eq("rst_d_corrupt", d_corrupt, 0);
        check_eq("rst_d_data", d_data, 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("a_ready_before_edge", a_ready, 0);
        @(posedge clock); #1;
        check_eq("a_ready_after_release", a_ready, 1);

        // Fill the whole array so every model word is known.
        for (int w = 0; w < DEPTH; w += 8) begin
            for (int b = 0; b < 8; b++) begin
                bd[b] = {$urandom, $urandom}; bm[b] = 8'hFF; bc[b] = 1'b0;
            end
            do_put(3'd0, 3'd6, 8'(w), BASE + 31'(w * 8), 0);
        end

        bd[0] = 64'h0123_4567_89AB_CDEF; bm[0] = 8'hFF; bc[0] = 1'b0;
        do_put(3'd0, 3'd3, 8'h12, BASE, 0);
        do_get(3'd3, 8'h21, BASE, 0, cyc);

        for (int b = 0; b < 8; b++) begin
            bd[b] = 64'(b); bm[b] = 8'hFF; bc[b] = 1'b0;
        end
        do_put(3'd0, 3'd6, 8'h33, BASE, 0);
        do_get(3'd6, 8'h34, BASE, 0, cyc);
        check_eq("burst_cycles", cyc, 8);

        bd[0] = 64'd0; bm[0] = 8'hFF; bc[0] = 1'b0;
        do_put(3'd0, 3'd3, 8'h40, BASE, 0);
        bd[0] = 64'hFFFF_FFFF_FFFF_FFFF; bm[0] = 8'h0F;
        do_put(3'd1, 3'd3, 8'h41, BASE, 1);
        do_get(3'd3, 8'h42, BASE, 0, cyc);

        do_get(3'd6, 8'h50, BASE + 31'd64, 1, cyc);

        do_get(3'd3, 8'h60, BASE + 31'(WIN), 0, cyc);
        do_bad(3'd3, 3'd3, 8'h61, BASE, 0);

        // Reset in the middle of an 8-beat PutFull after three beats.
        for (int b = 0; b < 8; b++) begin
            bd[b] = {$urandom, $urandom}; bm[b] = 8'hFF; bc[b] = 1'b0;
        end
        d_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            drive_beat(3'd0, 3'd6, 8'h70, BASE, bm[b], bd[b], bc[b], ok);
            if (ok) ref_mem[b] = bd[b];
        end
        reset = 1'b0;
        #1;
        check_eq("midrst_d_valid", d_valid, 0);
        check_eq("midrst_a_ready", a_ready, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check_eq("midrst_a_ready_after", a_ready, 1);
        repeat (3) begin
            @(posedge clock); #1;
            check_eq("midrst_no_d", d_valid, 0);
        end
        d_ready = 1'b0;
        do_get(3'd6, 8'h71, BASE, 0, cyc);

        for (int t = 0; t < 200; t++) begin
            r    = $urandom_range(0, 99);
            size = (r < 3) ? 7 : $urandom_range(0, 6);
            sz   = 3'(size);
            off  = $urandom_range(0, WIN - 1) & ~((1 << size) - 1);
            st   = $urandom_range(0, 11);
            if (st == 0)      addr = BASE + 31'(WIN) + 31'(off);
            else if (st == 1) addr = BASE - 31'd128;
            else              addr = BASE + 31'(off);
            for (int b = 0; b < 16; b++) begin
                bd[b] = {$urandom, $urandom};
                bm[b] = 8'($urandom_range(0, 255));
                bc[b] = ($urandom_range(0, 9) == 0);
            end
            r = $urandom_range(0, 99);
            if (r < 45) begin
                do_get(sz, 8'($urandom_range(0, 255)), addr, 2, cyc);
            end else if (r < 70) begin
                for (int b = 0; b < 16; b++) bm[b] = 8'hFF;
                do_put(3'd0, sz, 8'($urandom_range(0, 255)), addr, $urandom_range(0, 2));
            end else if (r < 92) begin
                do_put(3'd1, sz, 8'($urandom_range(0, 255)), addr, $urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0: op = 3'd2;
                    1: op = 3'd3;
                    2: op = 3'd5;
                    3: op = 3'd6;
                    default: op = 3'd7;
                endcase
                do_bad(op, sz, 8'($urandom_range(0, 255)), addr, $urandom_range(0, 2));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
